// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU engine: control codes, slice ops, FSM states.
package alu_pkg;

  localparam int unsigned CTRL_W = 4;
  localparam int unsigned OP_W   = 2;

  localparam logic [CTRL_W-1:0] CTRL_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] CTRL_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] CTRL_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] CTRL_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] CTRL_SLT = 4'b0111;
  localparam logic [CTRL_W-1:0] CTRL_NOR = 4'b1100;

  localparam logic [OP_W-1:0] OP_AND  = 2'b00;
  localparam logic [OP_W-1:0] OP_OR   = 2'b01;
  localparam logic [OP_W-1:0] OP_ADD  = 2'b10;
  localparam logic [OP_W-1:0] OP_LESS = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice drive derived from a control code; valid=0 marks an unsupported code.
  typedef struct packed {
    logic            valid;
    logic            inv_a;
    logic            inv_b;
    logic [OP_W-1:0] op;
  } slice_cfg_t;

  // Map a control code to the slice drive triple.
  function automatic slice_cfg_t decode_ctrl(input logic [CTRL_W-1:0] ctrl);
    slice_cfg_t cfg;
    cfg = '{valid: 1'b0, inv_a: 1'b0, inv_b: 1'b0, op: OP_AND};
    case (ctrl)
      CTRL_AND: cfg = '{valid: 1'b1, inv_a: 1'b0, inv_b: 1'b0, op: OP_AND};
      CTRL_OR:  cfg = '{valid: 1'b1, inv_a: 1'b0, inv_b: 1'b0, op: OP_OR};
      CTRL_ADD: cfg = '{valid: 1'b1, inv_a: 1'b0, inv_b: 1'b0, op: OP_ADD};
      CTRL_SUB: cfg = '{valid: 1'b1, inv_a: 1'b0, inv_b: 1'b1, op: OP_ADD};
      CTRL_SLT: cfg = '{valid: 1'b1, inv_a: 1'b0, inv_b: 1'b1, op: OP_ADD};
      CTRL_NOR: cfg = '{valid: 1'b1, inv_a: 1'b1, inv_b: 1'b1, op: OP_AND};
      default:  cfg = '{valid: 1'b0, inv_a: 1'b0, inv_b: 1'b0, op: OP_AND};
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/serial_alu_engine_if.sv
// Request/response bundle between a requester and the serial ALU engine.
interface serial_alu_engine_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [3:0]       alu_ctrl_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             cout_o;
  logic             overflow_o;

  modport master (
    output start_i, src1_i, src2_i, alu_ctrl_i,
    input  busy_o, done_o, result_o, zero_o, cout_o, overflow_o
  );

  modport slave (
    input  start_i, src1_i, src2_i, alu_ctrl_i,
    output busy_o, done_o, result_o, zero_o, cout_o, overflow_o
  );
endinterface

// File: rtl/alu_bit_slice.sv
// Single-bit ALU slice: optional operand inversion, then AND / OR / full-add / less.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic            a,
  input  logic            b,
  input  logic            invertA,
  input  logic            invertB,
  input  logic [OP_W-1:0] operation,
  input  logic            carryIn,
  input  logic            less,
  output logic            result,
  output logic            carryOut
);

  logic a_c;
  logic b_c;

  assign a_c = a ^ invertA;
  assign b_c = b ^ invertB;

  // Carry is always produced by the adder path; only ADD consumes it downstream.
  assign carryOut = (a_c & b_c) | (a_c & carryIn) | (b_c & carryIn);

  // Result mux on the operation code.
  always_comb begin
    result = 1'b0;
    case (operation)
      OP_AND:  result = a_c & b_c;
      OP_OR:   result = a_c | b_c;
      OP_ADD:  result = a_c ^ b_c ^ carryIn;
      OP_LESS: result = less;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_engine.sv
// Bit-serial ALU: latches operands, runs one slice LSB-first for WIDTH cycles, returns result and flags.
module serial_alu_engine
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  serial_alu_engine_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_sh_q, res_sh_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  slice_cfg_t         cfg_c;
  logic               slice_res_c;
  logic               slice_cout_c;
  logic               last_c;
  logic [WIDTH-1:0]   sum_full_c;
  logic               ovf_full_c;

  assign cfg_c      = decode_ctrl(ctrl_q);
  assign last_c     = (cnt_q == CNT_W'(WIDTH - 1));
  assign sum_full_c = {slice_res_c, res_sh_q[WIDTH-1:1]};
  // Carry into the MSB is the carry register before its final update.
  assign ovf_full_c = carry_q ^ slice_cout_c;

  alu_bit_slice u_slice (
    .a         (a_sh_q[0]),
    .b         (b_sh_q[0]),
    .invertA   (cfg_c.inv_a),
    .invertB   (cfg_c.inv_b),
    .operation (cfg_c.op),
    .carryIn   (carry_q),
    .less      (1'b0),
    .result    (slice_res_c),
    .carryOut  (slice_cout_c)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: DONE always returns to IDLE; start is only seen in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = RUN;
      RUN:     if (last_c)      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    ctrl_d   = ctrl_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    busy_d   = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          a_sh_d   = bus.src1_i;
          b_sh_d   = bus.src2_i;
          res_sh_d = '0;
          ctrl_d   = bus.alu_ctrl_i;
          carry_d  = (bus.alu_ctrl_i == CTRL_SUB) || (bus.alu_ctrl_i == CTRL_SLT);
          cnt_d    = '0;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = sum_full_c;
        carry_d  = slice_cout_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_c) begin
          done_d = 1'b1;
          cout_d = 1'b0;
          ovf_d  = 1'b0;
          if ((ctrl_q == CTRL_ADD) || (ctrl_q == CTRL_SUB)) begin
            result_d = sum_full_c;
            cout_d   = slice_cout_c;
            ovf_d    = ovf_full_c;
          end else if (ctrl_q == CTRL_SLT) begin
            result_d = {{(WIDTH-1){1'b0}}, slice_res_c ^ ovf_full_c};
          end else if (cfg_c.valid) begin
            result_d = sum_full_c;
          end else begin
            result_d = '0;
          end
          zero_d = (result_d == '0);
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      ctrl_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      ctrl_q   <= ctrl_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.result_o   = result_q;
  assign bus.zero_o     = zero_q;
  assign bus.cout_o     = cout_q;
  assign bus.overflow_o = ovf_q;

endmodule

// File: tb/tb_serial_alu_engine.sv
// Directed self-checking bench for serial_alu_engine (WIDTH = 32).
module tb_serial_alu_engine;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  serial_alu_engine_if #(.WIDTH(WIDTH)) bus ();

  serial_alu_engine #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Present a request and step through the accepting edge; start is left as given by hold.
  task automatic issue(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input bit hold);
    bus.start_i    = 1'b1;
    bus.alu_ctrl_i = ctrl;
    bus.src1_i     = a;
    bus.src2_i     = b;
    @(posedge clk); #1;
    check("busy_after_accept", 32'(bus.busy_o), 32'd1);
    if (!hold) bus.start_i = 1'b0;
  endtask

  // Wait (bounded) for done; returns edges counted since the accepting edge.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done_o) break;
    end
    if (!bus.done_o) check("done_timeout", 32'(bus.done_o), 32'd1);
  endtask

  // Check result and flags, then step into IDLE confirming a one-cycle done pulse.
  task automatic expect_res(input string tag, input logic [31:0] res, input logic z,
                            input logic co, input logic ov);
    check({tag, "_result"}, bus.result_o, res);
    check({tag, "_zero"},   32'(bus.zero_o), 32'(z));
    check({tag, "_cout"},   32'(bus.cout_o), 32'(co));
    check({tag, "_ovf"},    32'(bus.overflow_o), 32'(ov));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(bus.done_o), 32'd0);
    check({tag, "_idle"},       32'(bus.busy_o), 32'd0);
  endtask

  // Full operation: issue, wait, check.
  task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic z,
                        input logic co, input logic ov);
    int cyc;
    issue(ctrl, a, b, 1'b0);
    wait_done(cyc);
    expect_res(tag, res, z, co, ov);
  endtask

  initial begin
    int cyc;
    bus.start_i    = 1'b0;
    bus.src1_i     = '0;
    bus.src2_i     = '0;
    bus.alu_ctrl_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   32'(bus.busy_o), 32'd0);
    check("rst_done",   32'(bus.done_o), 32'd0);
    check("rst_result", bus.result_o, 32'd0);
    check("rst_zero",   32'(bus.zero_o), 32'd0);
    check("rst_cout",   32'(bus.cout_o), 32'd0);
    check("rst_ovf",    32'(bus.overflow_o), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD with signed overflow; latency from accepting edge to done.
    issue(CTRL_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done(cyc);
    check("add_latency", 32'(cyc), 32'd32);
    expect_res("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1);

    run_op("sub_eq",   CTRL_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    run_op("slt_neg",  CTRL_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_op("slt_ovf",  CTRL_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    run_op("nor",      CTRL_NOR, 32'h0F0F_0000, 32'h0000_0F0F, 32'hF0F0_F0F0, 1'b0, 1'b0, 1'b0);
    run_op("and",      CTRL_AND, 32'h0F0F_0000, 32'h0000_0F0F, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    run_op("or",       CTRL_OR,  32'h0F0F_0000, 32'h0000_0F0F, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap", CTRL_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    run_op("sub_neg",  CTRL_SUB, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_ovf",  CTRL_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    run_op("invalid",  4'b0011,  32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0);

    // start pulse during RUN with different operands is ignored.
    issue(CTRL_ADD, 32'h0000_0001, 32'h0000_0002, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    bus.start_i    = 1'b1;
    bus.alu_ctrl_i = CTRL_OR;
    bus.src1_i     = 32'hFFFF_0000;
    bus.src2_i     = 32'h0000_FFFF;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.src1_i  = 32'hDEAD_BEEF;
    wait_done(cyc);
    check("ignore_latency", 32'(cyc + 6), 32'd32);
    expect_res("ignore_start", 32'h0000_0003, 1'b0, 1'b0, 1'b0);

    // start held across done: second op accepted on the first IDLE edge.
    issue(CTRL_ADD, 32'h0000_0010, 32'h0000_0020, 1'b1);
    bus.alu_ctrl_i = CTRL_SUB;
    bus.src1_i     = 32'h0000_0064;
    bus.src2_i     = 32'h0000_0014;
    wait_done(cyc);
    check("held_first_result", bus.result_o, 32'h0000_0030);
    @(posedge clk); #1;
    check("held_idle_gap", 32'(bus.busy_o), 32'd0);
    @(posedge clk); #1;
    check("held_accept", 32'(bus.busy_o), 32'd1);
    bus.start_i = 1'b0;
    wait_done(cyc);
    check("held_latency", 32'(cyc), 32'd32);
    expect_res("held_second", 32'h0000_0050, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-run clears everything immediately.
    run_op("pre_rst", CTRL_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
    issue(CTRL_SUB, 32'h0000_0001, 32'h0000_0002, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy",   32'(bus.busy_o), 32'd0);
    check("arst_done",   32'(bus.done_o), 32'd0);
    check("arst_result", bus.result_o, 32'd0);
    check("arst_zero",   32'(bus.zero_o), 32'd0);
    check("arst_cout",   32'(bus.cout_o), 32'd0);
    check("arst_ovf",    32'(bus.overflow_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", 32'(bus.busy_o), 32'd0);
    issue(CTRL_ADD, 32'h0000_0003, 32'h0000_0004, 1'b0);
    wait_done(cyc);
    check("post_rst_latency", 32'(cyc), 32'd32);
    expect_res("post_rst_add", 32'h0000_0007, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
